// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice: datapath width,
// the canonical NOP encoding and the fetch controller state type.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented on the instruction port while nothing
  // has been fetched yet.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register: reset to RESET_PC, load a word-aligned
// redirect target, or step by one instruction word. Load beats increment.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter int          s        = XLEN,
  parameter logic [s-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [s-1:0] load_pc,
  input  logic         incr,
  output logic [s-1:0] fetch_pc
);

  logic [s-1:0] fetch_pc_q;
  logic [s-1:0] fetch_pc_d;

  // Next fetch address: redirect target (low two bits forced to zero) or pc+4.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (load) begin
      fetch_pc_d = load_pc & ~s'(3);
    end else if (incr) begin
      fetch_pc_d = fetch_pc_q + s'(4);
    end
  end

  // Fetch address register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one word request at a time to instruction
// memory, holds the returned word and its pc for decode behind a
// valid/ready handshake, and drops fetches made stale by a redirect.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int           s        = XLEN,
  parameter logic [s-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [s-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [s-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [s-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [s-1:0] instruction,
  output logic [s-1:0] pc,
  output logic [s-1:0] pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [s-1:0] instruction_q, instruction_d;
  logic [s-1:0] pc_q, pc_d;
  // Address of the request left in flight when a redirect arrived; it must
  // stay on imem_addr until the memory acknowledges it.
  logic [s-1:0] discard_addr_q, discard_addr_d;

  logic [s-1:0] fetch_pc;
  logic         pc_load;
  logic         pc_incr;

  fetch_pc_reg #(
    .s        (s),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_pc  (redirect_pc),
    .incr     (pc_incr),
    .fetch_pc (fetch_pc)
  );

  // Next-state and capture decisions; a redirect always retargets fetch_pc.
  always_comb begin
    state_d        = state_q;
    instruction_d  = instruction_q;
    pc_d           = pc_q;
    discard_addr_d = discard_addr_q;
    pc_load        = redirect;
    pc_incr        = 1'b0;
    case (state_q)
      REQ: begin
        if (redirect) begin
          // With an ack this cycle the old request is finished and its
          // data is simply not captured; otherwise it is still in flight.
          if (!imem_ack) begin
            state_d        = DISCARD;
            discard_addr_d = fetch_pc;
          end
        end else if (imem_ack) begin
          instruction_d = imem_rdata;
          pc_d          = fetch_pc;
          pc_incr       = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (redirect || instr_ready) begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Controller state and held instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= REQ;
      instruction_q  <= s'(NOP_INSTR);
      pc_q           <= RESET_PC;
      discard_addr_q <= RESET_PC;
    end else begin
      state_q        <= state_d;
      instruction_q  <= instruction_d;
      pc_q           <= pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  // Request is suppressed while reset is held so it first rises in the
  // cycle after reset is released.
  assign imem_req    = (state_q != HOLD) && !reset;
  assign imem_addr   = (state_q == DISCARD) ? discard_addr_q : fetch_pc;
  assign instr_valid = (state_q == HOLD);
  assign instruction = instruction_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + s'(4);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a latency-programmable memory model, a
// scoreboard of expected (pc, instruction) hand-overs popped on each
// valid&ready cycle, and directed scenarios for redirect and reset cases.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // second instance, reset vector at the top of the address space
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [31:0] instruction2;
  logic [31:0] pc2;
  logic [31:0] pc_plus4_2;

  int n_cmp = 0;
  int n_err = 0;

  // memory model controls
  bit          mem_en;
  int          lat;
  int          n_acks = 0;
  logic        man_ack;
  logic [31:0] man_rdata;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  instruction_fetch #(.s(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  instruction_fetch #(.s(32), .RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_ack    (imem_ack2),
    .imem_rdata  (imem_rdata2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .instr_valid (instr_valid2),
    .instr_ready (instr_ready2),
    .instruction (instruction2),
    .pc          (pc2),
    .pc_plus4    (pc_plus4_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = instr_of(a);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory model: acts 1 time unit after each falling edge. Answers after
  // 'lat' wait cycles (0 = same cycle as the request). The second instance
  // always sees a zero-wait memory.
  initial begin
    int cnt;
    cnt         = 0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    imem_ack2   = 1'b0;
    imem_rdata2 = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_ack2   = imem_req2;
      imem_rdata2 = instr_of(imem_addr2);
      if (!mem_en) begin
        imem_ack   = man_ack;
        imem_rdata = man_rdata;
        cnt        = 0;
      end else begin
        imem_ack = 1'b0;
        if (imem_req) begin
          if (cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = instr_of(imem_addr);
            cnt        = 0;
            n_acks++;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    #2;
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_handover", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_pc", pc, e.pc);
        check_eq("sb_instr", instruction, e.instr);
        check_eq("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  task automatic do_reset();
    tick();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_en      = 1'b1;
    lat         = 0;
    man_ack     = 1'b0;
    man_rdata   = '0;
    tick();
    tick();
    #3;
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instruction, 32'h0000_0013);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_top_addr", imem_addr2, 32'hFFFF_FFFC);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!instr_valid && k < max) begin
      tick();
      #3;
      k++;
    end
    check_eq(tag, instr_valid, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int k;
    reset        = 1'b1;
    instr_ready  = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    mem_en       = 1'b1;
    lat          = 0;
    man_ack      = 1'b0;
    man_rdata    = '0;
    redirect2    = 1'b0;
    redirect_pc2 = '0;
    instr_ready2 = 1'b1;

    // 1: zero-wait memory, decode always ready
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    tick(); reset = 1'b0; instr_ready = 1'b1; #3;
    check_eq("t1_first_req", imem_req, 1);
    check_eq("t1_first_addr", imem_addr, 32'h0);
    tick(); #3;
    check_eq("t1_valid", instr_valid, 1);
    check_eq("t1_instr", instruction, 32'h0050_0093);
    check_eq("t1_pc_plus4", pc_plus4, 32'h4);
    tick(); #3;
    check_eq("t1_next_addr", imem_addr, 32'h4);
    tick(); #3;
    check_eq("t1_pc2", pc, 32'h4);

    // 2: three wait cycles, decode stalled for 5 cycles
    do_reset();
    lat = 3;
    push_exp(32'h0);
    tick(); reset = 1'b0; a0 = n_acks; #3;
    k = 0;
    while (!instr_valid && k < 10) begin
      check_eq("t2_req_held", imem_req, 1);
      check_eq("t2_addr_stable", imem_addr, 32'h0);
      tick(); #3;
      k++;
    end
    check_eq("t2_valid", instr_valid, 1);
    check_eq("t2_req_cycles", k, 4);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_valid", instr_valid, 1);
      check_eq("t2_hold_pc", pc, 32'h0);
      check_eq("t2_hold_instr", instruction, instr_of(32'h0));
      check_eq("t2_no_req", imem_req, 0);
      tick(); #3;
    end
    check_eq("t2_one_outstanding", n_acks - a0, 1);
    tick(); instr_ready = 1'b1; #3;

    // 3: redirect one cycle into a slow fetch of 0x8
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h100);
    tick(); reset = 1'b0; instr_ready = 1'b1; #3;
    tick(); #3;
    check_eq("t3_pc0", pc, 32'h0);
    tick(); #3;
    tick(); lat = 3; #3;
    check_eq("t3_pc4", pc, 32'h4);
    tick(); #3;
    check_eq("t3_addr8", imem_addr, 32'h8);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #3;
    tick(); redirect = 1'b0; #3;
    check_eq("t3_old_addr_held", imem_addr, 32'h8);
    check_eq("t3_old_req_held", imem_req, 1);
    tick(); #3;
    check_eq("t3_ack_dropped", instr_valid, 0);
    tick(); #3;
    check_eq("t3_target_addr", imem_addr, 32'h100);
    wait_valid("t3_target_valid", 12);
    check_eq("t3_target_pc", pc, 32'h100);

    // 4a: redirect in HOLD while decode stalls
    do_reset();
    push_exp(32'h40);
    tick(); reset = 1'b0; #3;
    tick(); #3;
    check_eq("t4a_valid", instr_valid, 1);
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #3;
    tick(); redirect = 1'b0; #3;
    check_eq("t4a_valid_drop", instr_valid, 0);
    check_eq("t4a_addr", imem_addr, 32'h40);
    tick(); instr_ready = 1'b1; #3;
    check_eq("t4a_pc", pc, 32'h40);

    // 4b: redirect in HOLD in the same cycle decode accepts
    do_reset();
    push_exp(32'h0);
    push_exp(32'h40);
    tick(); reset = 1'b0; instr_ready = 1'b1; #3;
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #3;
    check_eq("t4b_valid", instr_valid, 1);
    tick(); redirect = 1'b0; #3;
    check_eq("t4b_addr", imem_addr, 32'h40);
    tick(); #3;
    check_eq("t4b_pc", pc, 32'h40);

    // 5: reset vector at 0xFFFF_FFFC wraps to 0
    do_reset();
    tick(); reset = 1'b0; #3;
    check_eq("t5_first_addr", imem_addr2, 32'hFFFF_FFFC);
    tick(); #3;
    check_eq("t5_pc", pc2, 32'hFFFF_FFFC);
    check_eq("t5_pc_plus4", pc_plus4_2, 32'h0);
    tick(); #3;
    check_eq("t5_wrap_addr", imem_addr2, 32'h0);
    tick(); #3;
    check_eq("t5_wrap_pc", pc2, 32'h0);
    check_eq("t5_wrap_instr", instruction2, instr_of(32'h0));

    // 6: reset while a fetch is pending, ack arrives during reset
    do_reset();
    tick(); reset = 1'b0; mem_en = 1'b0; #3;
    check_eq("t6_req", imem_req, 1);
    tick(); #3;
    tick(); reset = 1'b1; #3;
    check_eq("t6_req_in_reset", imem_req, 0);
    tick(); man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF; #3;
    check_eq("t6_valid_in_reset", instr_valid, 0);
    push_exp(32'h0);
    tick(); man_ack = 1'b0; reset = 1'b0; mem_en = 1'b1; instr_ready = 1'b1; #3;
    check_eq("t6_ack_ignored_valid", instr_valid, 0);
    check_eq("t6_ack_ignored_instr", instruction, 32'h0000_0013);
    check_eq("t6_restart_addr", imem_addr, 32'h0);
    check_eq("t6_restart_req", imem_req, 1);
    tick(); #3;
    check_eq("t6_restart_pc", pc, 32'h0);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
